seg_score_display: RTL and testbench
====================================

SEG_SCORE_DISPLAY -- requirements
Module: seg_score_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL set clk cycles per digit slot (50 MHz clk: 1 kHz slot, 125 Hz frame).
REQ-002 Parameter BLINK_DIV, default 25000000, SHALL set clk cycles per blink half-period (0.5 s).
REQ-003 Parameter INIT_LEN, default 3, SHALL set the snake length that counts as score 0.
REQ-004 clk  input  1  system clock, one clock domain; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 snake_length  input  6  current snake length, unsigned.
REQ-007 game_state  input  2  00 RUNNING, 01 DIE, 10 INITIAL; 11 SHALL be treated as INITIAL.
REQ-008 AN  output  8  digit enables, active-low, exactly one bit low outside reset.
REQ-009 seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

Function
REQ-010 score SHALL equal snake_length-INIT_LEN if snake_length>=INIT_LEN, else 0 (no wrap).
REQ-011 A sequential double-dabble converter SHALL turn the 6-bit score into two BCD digits: start when score differs from the last converted value and converter idle; 6 shift iterations; BCD result registers update exactly 7 cycles after start.
REQ-012 A score change while the converter is busy SHALL NOT restart it; the new value converts on the first idle cycle after completion.
REQ-013 hi_score (6 bits) SHALL load score in the cycle game_state changes from RUNNING to DIE if score>hi_score; otherwise it holds; it SHALL be cleared only by rst.
REQ-014 hi_score SHALL be converted by a second instance of the same converter, under the rules of REQ-011/012.
REQ-015 A scan counter SHALL count 0..SCAN_DIV-1; on wrap a 3-bit digit index increments modulo 8 (7 -> 0).
REQ-016 AN SHALL be ~(8'b1<<index), registered, changing in the same cycle as seg.
REQ-017 Digit map: idx0 score units, idx1 score tens, idx2-3 blank, idx4 state glyph, idx5 blank, idx6 hi units, idx7 hi tens.
REQ-018 Tens digit 0 SHALL display blank (leading-zero suppression); units always shown.
REQ-019 Glyphs (seg hex): 0 C0,1 F9,2 A4,3 B0,4 99,5 92,6 82,7 F8,8 80,9 90, blank FF, dash BF, P 8C, E 86.
REQ-020 State glyph: RUNNING P, DIE E, INITIAL/11 dash.
REQ-021 A blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap; it SHALL be held at 0 with phase 0 while game_state is not DIE, so blinking always starts visible.
REQ-022 In DIE with blink_phase=1, idx0/idx1 SHALL show blank; all other digits unaffected.
REQ-023 In INITIAL, idx0/idx1 SHALL show dash.
REQ-024 dp SHALL be off (1) on every digit.

Reset
REQ-025 While rst=1: AN=8'hFF, seg=8'hFF, counters, index, blink_phase, hi_score, converters, BCD registers and last-converted values all 0, converters idle.
REQ-026 First cycle after rst release SHALL start scanning at index 0; rst asserted mid-conversion SHALL abort it with no partial BCD update.
REQ-027 Outputs SHALL be glitch-free registers; no combinational path from inputs to AN/seg.

Verification (SCAN_DIV=4, BLINK_DIV=8, INIT_LEN=3)
REQ-028 rst pulse -> AN=FF, seg=FF during reset; after release AN sequence FE,FD,...,7F,FE each held 4 cycles.
REQ-029 RUNNING, snake_length 3->45 -> BCD updates 7 cycles later; idx0 seg=A4, idx1 seg=99, idx4 seg=8C.
REQ-030 snake_length=1 -> score 0: idx0 C0, idx1 FF; snake_length=63 -> idx0 C0, idx1 82.
REQ-031 length 20 RUNNING->DIE -> hi_score=17 (idx7 F9, idx6 F8); idx4 86; idx0/1 visible 8 cycles then blank 8 cycles, repeating; next game ending with score 5 leaves hi_score 17.
REQ-032 snake_length changes twice within a 7-cycle conversion -> only final value shown after second conversion; no intermediate corrupt digit.
REQ-033 game_state=11 -> idx4 BF and idx0/1 BF, identical to INITIAL.

Source files
------------

// File: rtl/seg_score_display.sv
// seg_score_display: eight-digit multiplexed seven-segment driver for a snake
// game. Digit slots show the current score, a state glyph and the high score.
// Both numbers are turned into BCD by small sequential double-dabble units.
// Every output is registered, so AN and seg never glitch.
module seg_score_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000,
    parameter int INIT_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] snake_length,
    input  logic [1:0] game_state,
    output logic [7:0] AN,
    output logic [7:0] seg
);

    // Game state encodings; 2'b11 is decoded the same way as INITIAL.
    localparam logic [1:0] ST_RUNNING = 2'b00;
    localparam logic [1:0] ST_DIE     = 2'b01;
    localparam logic [1:0] ST_INITIAL = 2'b10;

    // Segment patterns, active-low, dp (bit 7) always off.
    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_P     = 8'h8C;
    localparam logic [7:0] GLYPH_E     = 8'h86;

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [5:0]         INIT_LEN_6 = 6'(INIT_LEN);

    // Number of shift iterations needed to convert a 6-bit binary value.
    localparam logic [2:0] DD_STEPS = 3'd6;

    // Seven-segment pattern for one BCD digit.
    function automatic logic [7:0] digit_glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // One double-dabble iteration: bias each BCD nibble that is >= 5 by 3,
    // then shift the whole scratch word left by one bit.
    // Layout: [13:10] tens, [9:6] units, [5:0] remaining binary bits.
    function automatic logic [13:0] dd_step(input logic [13:0] s);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = s[13:10];
        units = s[9:6];
        if (units >= 4'd5) units = units + 4'd3;
        if (tens  >= 4'd5) tens  = tens  + 4'd3;
        return {tens[2:0], units, s[5:0], 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Score and game-state decode
    // ------------------------------------------------------------------
    logic [5:0] score;
    logic       st_running;
    logic       st_die;
    logic       st_initial;

    // Score saturates at zero for snakes shorter than the starting length.
    assign score      = (snake_length >= INIT_LEN_6) ? (snake_length - INIT_LEN_6) : 6'd0;
    assign st_running = (game_state == ST_RUNNING);
    assign st_die     = (game_state == ST_DIE);
    assign st_initial = game_state[1];

    // ------------------------------------------------------------------
    // High score: captured on the RUNNING -> DIE transition
    // ------------------------------------------------------------------
    logic [1:0] prev_state;
    logic [5:0] hi_score;

    // Track last cycle's state and latch a new record when a game ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Reset to INITIAL so a DIE seen right after reset is not a game end.
            prev_state <= ST_INITIAL;
            hi_score   <= 6'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            prev_state <= game_state;
            if (prev_state == ST_RUNNING && st_die && score > hi_score) begin
                hi_score <= score;
            end
        end
    end

    // ------------------------------------------------------------------
    // Two sequential binary-to-BCD converters (0: score, 1: hi_score)
    // ------------------------------------------------------------------
    logic [3:0] bcd_units [2];
    logic [3:0] bcd_tens  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_conv
        logic [5:0]  conv_in;
        logic [5:0]  last_val;
        logic        busy;
        logic [2:0]  step;
        logic [13:0] scratch;
        logic [3:0]  units_q;
        logic [3:0]  tens_q;

        assign conv_in = (gi == 0) ? score : hi_score;

        // Start on a new value when idle, iterate six times, then publish.
        // The start cycle is t, iterations run at t+1..t+6 and the BCD
        // registers load at t+7. A value change while busy is picked up by
        // the idle-cycle compare once this conversion has finished.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                last_val <= 6'd0;
                busy     <= 1'b0;
                step     <= 3'd0;
                scratch  <= 14'd0;
                units_q  <= 4'd0;
                tens_q   <= 4'd0;
            end else if (!busy) begin
                if (conv_in != last_val) begin
                    busy     <= 1'b1;
                    step     <= 3'd0;
                    scratch  <= {8'd0, conv_in};
                    last_val <= conv_in;
                end
            end else if (step != DD_STEPS) begin
                scratch <= dd_step(scratch);
                step    <= step + 3'd1;
            end else begin
                tens_q  <= scratch[13:10];
                units_q <= scratch[9:6];
                busy    <= 1'b0;
            end
        end

        assign bcd_units[gi] = units_q;
        assign bcd_tens[gi]  = tens_q;
    end

    // ------------------------------------------------------------------
    // Digit scan timing
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit_idx;

    // Advance to the next digit slot every SCAN_DIV cycles; index wraps 7 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Blink timing for the score digits after a game ends
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Held at zero outside DIE so the first half-period is always visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!st_die) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Segment selection and output registers
    // ------------------------------------------------------------------
    logic [7:0] seg_next;
    logic       score_hidden;

    assign score_hidden = st_die && blink_phase;

    // Choose the pattern for the slot currently being scanned.
    always_comb begin
        // NOTE: the default assignment up front keeps every path driven, so
        // no latch is inferred for the slots the case leaves out.
        seg_next = GLYPH_BLANK;
        case (digit_idx)
            3'd0: begin
                if (st_initial)        seg_next = GLYPH_DASH;
                else if (score_hidden) seg_next = GLYPH_BLANK;
                else                   seg_next = digit_glyph(bcd_units[0]);
            end
            3'd1: begin
                if (st_initial)                              seg_next = GLYPH_DASH;
                else if (score_hidden || bcd_tens[0] == 4'd0) seg_next = GLYPH_BLANK;
                else                                         seg_next = digit_glyph(bcd_tens[0]);
            end
            3'd4: begin
                if (st_running)  seg_next = GLYPH_P;
                else if (st_die) seg_next = GLYPH_E;
                else             seg_next = GLYPH_DASH;
            end
            3'd6: seg_next = digit_glyph(bcd_units[1]);
            3'd7: begin
                if (bcd_tens[1] == 4'd0) seg_next = GLYPH_BLANK;
                else                     seg_next = digit_glyph(bcd_tens[1]);
            end
            default: seg_next = GLYPH_BLANK;
        endcase
    end

    // Register anode and segment together so they switch on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN  <= 8'hFF;
            seg <= 8'hFF;
        end else begin
            AN  <= ~(8'b1 << digit_idx);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_score_display.sv
// Testbench for seg_score_display. Stimulus pushes the expected pattern of
// each digit slot into a queue; a monitor waits for that slot's anode and
// compares the segments. Expected values come from a plain arithmetic model.
module tb_seg_score_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;
    localparam int INIT_LEN  = 3;
    localparam int SLOT_WAIT = 2 * 8 * SCAN_DIV + 4;
    localparam int SETTLE    = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] snake_length = 6'd0;
    logic [1:0] game_state = 2'b10;
    logic [7:0] AN;
    logic [7:0] seg;

    seg_score_display #(
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV),
        .INIT_LEN (INIT_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .snake_length(snake_length),
        .game_state  (game_state),
        .AN          (AN),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        bit         blinkable;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    bit   mon_busy = 1'b0;

    // Posedges spent continuously in DIE; gives the blink phase by elapsed time.
    int die_cnt = 0;
    always @(posedge clk) begin
        if (rst || game_state != 2'b01) die_cnt <= 0;
        else                            die_cnt <= die_cnt + 1;
    end

    // Reference model state
    int m_len     = 0;
    int m_gs      = 2;
    int m_prev_gs = 2;
    int m_hi      = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int score_of(input int len);
        return (len >= INIT_LEN) ? len - INIT_LEN : 0;
    endfunction

    // Expected pattern of one slot for the current model state.
    function automatic exp_t model_slot(input int idx, input string tag);
        exp_t e;
        int   sc;
        int   st;
        sc = score_of(m_len);
        st = (m_gs == 3) ? 2 : m_gs;
        e.an        = ~(8'b1 << idx);
        e.seg       = 8'hFF;
        e.blinkable = 1'b0;
        e.name      = $sformatf("%s idx%0d", tag, idx);
        case (idx)
            0: begin
                if (st == 2) e.seg = 8'hBF;
                else begin
                    e.seg = glyph(sc % 10);
                    e.blinkable = (st == 1);
                end
            end
            1: begin
                if (st == 2) e.seg = 8'hBF;
                else begin
                    e.seg = (sc / 10 == 0) ? 8'hFF : glyph(sc / 10);
                    e.blinkable = (st == 1);
                end
            end
            4: e.seg = (st == 0) ? 8'h8C : (st == 1) ? 8'h86 : 8'hBF;
            6: e.seg = glyph(m_hi % 10);
            7: e.seg = (m_hi / 10 == 0) ? 8'hFF : glyph(m_hi / 10);
            default: e.seg = 8'hFF;
        endcase
        return e;
    endfunction

    task automatic push_frame(input string tag);
        for (int i = 0; i < 8; i++) sb_q.push_back(model_slot(i, tag));
    endtask

    // Drive new inputs at a negedge and advance the model.
    task automatic apply(input int len, input int gs, input int settle);
        @(negedge clk);
        snake_length = 6'(len);
        game_state   = 2'(gs);
        if (m_prev_gs == 0 && gs == 1 && score_of(len) > m_hi) m_hi = score_of(len);
        m_prev_gs = gs;
        m_len     = len;
        m_gs      = gs;
        repeat (settle) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int waited;
        waited = 0;
        while ((sb_q.size() != 0 || mon_busy) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0 || mon_busy) begin
            total++;
            bad++;
            $display("FAIL %s drain: %0d entries left, required 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: pop an expected slot, wait for its anode, compare segments.
    initial begin
        forever begin
            exp_t       e;
            int         waited;
            logic [7:0] s;
            @(negedge clk);
            if (sb_q.size() != 0) begin
                mon_busy = 1'b1;
                e = sb_q.pop_front();
                waited = 0;
                while (AN !== e.an && waited < SLOT_WAIT) begin
                    @(negedge clk);
                    waited++;
                end
                if (AN !== e.an) begin
                    check({e.name, " anode"}, AN, e.an);
                end else begin
                    s = e.seg;
                    if (e.blinkable && die_cnt > 0 && ((die_cnt - 1) / BLINK_DIV) % 2 == 1)
                        s = 8'hFF;
                    check({e.name, " seg"}, seg, s);
                end
                mon_busy = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("reset AN", AN, 8'hFF);
        check("reset seg", seg, 8'hFF);

        // Release and follow the anode scan from index 0 through a wrap.
        rst = 1'b0;
        for (int i = 0; i < 36; i++) begin
            logic [7:0] exp_an;
            @(negedge clk);
            exp_an = ~(8'b1 << ((i / SCAN_DIV) % 8));
            check($sformatf("scan sample %0d", i), AN, exp_an);
        end

        // Initial screen.
        push_frame("initial");
        drain("initial");

        // Running scores, including the saturating and maximum cases.
        apply(3, 0, SETTLE);  push_frame("len3");  drain("len3");
        apply(45, 0, SETTLE); push_frame("len45"); drain("len45");
        apply(1, 0, SETTLE);  push_frame("len1");  drain("len1");
        apply(63, 0, SETTLE); push_frame("len63"); drain("len63");

        // Game over at length 20: record 17, score digits blink.
        apply(20, 0, SETTLE);
        apply(20, 1, SETTLE);
        for (int j = 0; j < 4; j++) begin
            repeat (j * 5) @(negedge clk);
            push_frame($sformatf("die20 f%0d", j));
            drain("die20");
        end

        // A lower-scoring game leaves the record alone.
        apply(20, 2, SETTLE); push_frame("new game"); drain("new game");
        apply(8, 0, SETTLE);
        apply(8, 1, SETTLE);  push_frame("die8");     drain("die8");

        // Several changes inside one conversion window.
        apply(30, 0, 2);
        apply(40, 0, 2);
        apply(50, 0, SETTLE); push_frame("burst"); drain("burst");

        // Encoding 11 behaves like INITIAL.
        apply(10, 3, SETTLE); push_frame("state11"); drain("state11");

        // Reset in the middle of a conversion; record is cleared.
        apply(33, 0, 3);
        rst = 1'b1;
        m_hi = 0;
        repeat (2) @(negedge clk);
        check("mid reset AN", AN, 8'hFF);
        check("mid reset seg", seg, 8'hFF);
        rst = 1'b0;
        repeat (SETTLE) @(negedge clk);
        push_frame("after reset");
        drain("after reset");

        // Randomized inputs.
        for (int k = 0; k < 40; k++) begin
            int len;
            int gs;
            len = int'($urandom_range(0, 63));
            gs  = int'($urandom_range(0, 3));
            apply(len, gs, SETTLE + int'($urandom_range(0, 15)));
            push_frame($sformatf("rand%0d", k));
            drain("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
